ham_secded_decoder: RTL

//   Parametrised, pipelined extended-Hamming (SECDED) decoder.
//   - Takes a 2^R-bit codeword: Hamming bits [N:1] (N = 2^R-1) plus overall parity bit [0].
//   - Corrects any single-bit error, flags double-bit errors as uncorrectable.
//   - Extracts the K = N-R data bits.
//   - Sits between a storage/link receiver and its consumer, with valid/ready flow control.
//   - Keeps saturating error counters for status reporting.
//

---
 rtl/ham_secded_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ham_secded_decoder.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready flow control
// and saturating corrected/uncorrectable result counters.
module ham_secded_decoder #(
  parameter int R     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2**R-1:0]      in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**R-1:0]      out_code,
  output logic [2**R-R-2:0]    out_data,
  output logic                 out_corr,
  output logic                 out_uncorr,
  input  logic                 clr_counts,
  output logic [CNT_W-1:0]     corr_count,
  output logic [CNT_W-1:0]     uncorr_count
);

  localparam int CW = 2**R;
  localparam int N  = CW - 1;
  localparam int K  = N - R;

  function automatic logic [R-1:0] syndrome_f(input logic [CW-1:0] c);
    logic [R-1:0] s;
    s = '0;
    for (int i = 1; i < CW; i++) begin
      if (c[i]) s ^= R'(i);
    end
    return s;
  endfunction

  // With odd parity the syndrome names the bad bit; a zero syndrome lands on bit 0.
  function automatic logic [CW-1:0] correct_f(input logic [CW-1:0] c,
                                              input logic [R-1:0]  s,
                                              input logic          p);
    logic [CW-1:0] r;
    r = c;
    if (p) r[s] = ~r[s];
    return r;
  endfunction

  function automatic logic [K-1:0] extract_f(input logic [CW-1:0] c);
    logic [K-1:0] d;
    int           k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic              vld_p1_q, vld_p2_q;
  logic [CW-1:0]     code_p1_q;
  logic [R-1:0]      syn_p1_q, syn_p1_d;
  logic              par_p1_q, par_p1_d;
  logic [CW-1:0]     code_p2_q, code_p2_d;
  logic [K-1:0]      data_p2_q, data_p2_d;
  logic              corr_p2_q, corr_p2_d;
  logic              uncorr_p2_q, uncorr_p2_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic              s2_adv, xfer;

  assign s2_adv   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s2_adv;
  assign xfer     = vld_p2_q && out_ready;

  always_comb begin
    syn_p1_d    = syndrome_f(in_code);
    par_p1_d    = ^in_code;
    code_p2_d   = correct_f(code_p1_q, syn_p1_q, par_p1_q);
    data_p2_d   = extract_f(code_p2_d);
    corr_p2_d   = par_p1_q;
    uncorr_p2_d = !par_p1_q && (syn_p1_q != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (in_ready) vld_p1_q <= in_valid;
      if (s2_adv)   vld_p2_q <= vld_p1_q;
    end
  end

  // Stage 1: received word, syndrome, overall parity
  always_ff @(posedge clock) begin
    if (in_ready && in_valid) begin
      code_p1_q <= in_code;
      syn_p1_q  <= syn_p1_d;
      par_p1_q  <= par_p1_d;
    end
  end

  // Stage 2: corrected word, extracted data, flags
  always_ff @(posedge clock) begin
    if (s2_adv && vld_p1_q) begin
      code_p2_q   <= code_p2_d;
      data_p2_q   <= data_p2_d;
      corr_p2_q   <= corr_p2_d;
      uncorr_p2_q <= uncorr_p2_d;
    end
  end

  assign out_valid  = vld_p2_q;
  assign out_code   = vld_p2_q ? code_p2_q : '0;
  assign out_data   = vld_p2_q ? data_p2_q : '0;
  assign out_corr   = vld_p2_q && corr_p2_q;
  assign out_uncorr = vld_p2_q && uncorr_p2_q;

  // Clear wins over a same-cycle delivery, so that delivery goes uncounted.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (clr_counts) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (xfer) begin
      if (corr_p2_q)   corr_cnt_d   = sat_inc_f(corr_cnt_q);
      if (uncorr_p2_q) uncorr_cnt_d = sat_inc_f(uncorr_cnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_count   = corr_cnt_q;
  assign uncorr_count = uncorr_cnt_q;

endmodule
